// File: rtl/mon_pkg.sv
// Shared state and failure-code encodings for write_monitor and its bench.
package mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } mon_state_e;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_DATA    = 2'd1;
  localparam logic [1:0] FC_ADR     = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;

endpackage

// File: rtl/write_monitor_exp_table.sv
// Expected-write table: entry storage, matched mask and the combinational
// search that classifies an observed write as full match, address hit or miss.
module exp_table #(
  parameter int N_EXP   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter bit ORDERED = 1'b1,
  parameter int IDX_W   = 2,
  parameter int CNT_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ADDR_W-1:0] wr_adr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              mask_clr,
  input  logic              mask_set,
  input  logic [IDX_W-1:0]  mask_idx,
  input  logic [CNT_W-1:0]  sel,
  input  logic [ADDR_W-1:0] obs_adr,
  input  logic [DATA_W-1:0] obs_data,
  output logic              hit,
  output logic              full_match,
  output logic [IDX_W-1:0]  hit_idx
);

  logic [ADDR_W-1:0] adr_q  [N_EXP];
  logic [ADDR_W-1:0] adr_d  [N_EXP];
  logic [DATA_W-1:0] data_q [N_EXP];
  logic [DATA_W-1:0] data_d [N_EXP];
  logic [N_EXP-1:0]  mask_q;
  logic [N_EXP-1:0]  mask_d;

  always_comb begin
    adr_d  = adr_q;
    data_d = data_q;
    mask_d = mask_q;
    if (wr_en) begin
      for (int i = 0; i < N_EXP; i++) begin
        if (IDX_W'(i) == wr_idx) begin
          adr_d[i]  = wr_adr;
          data_d[i] = wr_data;
        end
      end
    end
    if (mask_clr) begin
      mask_d = '0;
    end else if (mask_set) begin
      for (int i = 0; i < N_EXP; i++) begin
        if (IDX_W'(i) == mask_idx) mask_d[i] = 1'b1;
      end
    end
  end

  // Unordered search walks downward so the lowest fully matching index wins;
  // an address-only hit anywhere among unmatched entries still flags hit.
  always_comb begin
    hit        = 1'b0;
    full_match = 1'b0;
    hit_idx    = '0;
    if (ORDERED) begin
      for (int i = 0; i < N_EXP; i++) begin
        if (CNT_W'(i) == sel) begin
          hit        = (adr_q[i] == obs_adr);
          full_match = (adr_q[i] == obs_adr) && (data_q[i] == obs_data);
          hit_idx    = IDX_W'(i);
        end
      end
    end else begin
      for (int i = N_EXP - 1; i >= 0; i--) begin
        if (!mask_q[i] && (adr_q[i] == obs_adr)) begin
          hit = 1'b1;
          if (data_q[i] == obs_data) begin
            full_match = 1'b1;
            hit_idx    = IDX_W'(i);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_EXP; i++) begin
        adr_q[i]  <= '0;
        data_q[i] <= '0;
      end
      mask_q <= '0;
    end else begin
      adr_q  <= adr_d;
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end

endmodule

// File: rtl/write_monitor.sv
// Data-memory write monitor: checks observed writes against a loaded table
// and reports pass, failure cause with the offending write, or timeout.
module write_monitor
  import mon_pkg::*;
#(
  parameter int              N_EXP   = 4,
  parameter int              ADDR_W  = 32,
  parameter int              DATA_W  = 32,
  parameter int              TIMEOUT = 1000,
  parameter bit              ORDERED = 1'b1,
  parameter bit              IGN_EN  = 1'b1,
  parameter logic [ADDR_W-1:0] IGN_ADR = 96,
  localparam int             IDX_W   = (N_EXP > 1) ? $clog2(N_EXP) : 1,
  localparam int             CNT_W   = $clog2(N_EXP + 1),
  localparam int             CYC_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [ADDR_W-1:0] exp_adr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              start,
  input  logic              clear,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Adr,
  input  logic [DATA_W-1:0] WriteData,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [ADDR_W-1:0] fail_adr,
  output logic [DATA_W-1:0] fail_data,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CYC_W-1:0]  cycle_cnt,
  output logic [1:0]        mon_state
);

  mon_state_e        state_q, state_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [1:0]        fc_q, fc_d;
  logic [ADDR_W-1:0] fa_q, fa_d;
  logic [DATA_W-1:0] fd_q, fd_d;
  logic [CNT_W-1:0]  mc_q, mc_d;
  logic [CYC_W-1:0]  cc_q, cc_d;

  logic              tbl_wr, mask_clr, mask_set;
  logic              hit, full_match;
  logic [IDX_W-1:0]  hit_idx;
  logic [CYC_W-1:0]  cc_inc;
  logic              eval_wr;

  exp_table #(
    .N_EXP   (N_EXP),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .ORDERED (ORDERED),
    .IDX_W   (IDX_W),
    .CNT_W   (CNT_W)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (tbl_wr),
    .wr_idx     (exp_idx),
    .wr_adr     (exp_adr),
    .wr_data    (exp_data),
    .mask_clr   (mask_clr),
    .mask_set   (mask_set),
    .mask_idx   (hit_idx),
    .sel        (mc_q),
    .obs_adr    (Adr),
    .obs_data   (WriteData),
    .hit        (hit),
    .full_match (full_match),
    .hit_idx    (hit_idx)
  );

  always_comb begin
    tbl_wr   = exp_we && (state_q == ST_IDLE);
    mask_clr = start && (state_q == ST_IDLE);
    eval_wr  = MemWrite && !(IGN_EN && (Adr == IGN_ADR));
    cc_inc   = (cc_q == {CYC_W{1'b1}}) ? cc_q : cc_q + CYC_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    pass_d   = pass_q;
    fc_d     = fc_q;
    fa_d     = fa_q;
    fd_d     = fd_q;
    mc_d     = mc_q;
    cc_d     = cc_q;
    mask_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          mc_d    = '0;
          cc_d    = '0;
          fc_d    = FC_NONE;
          fa_d    = '0;
          fd_d    = '0;
        end
      end
      ST_RUN: begin
        cc_d = cc_inc;
        if (eval_wr) begin
          if (full_match) begin
            mask_set = 1'b1;
            mc_d     = mc_q + CNT_W'(1);
            if (mc_q == CNT_W'(N_EXP - 1)) begin
              state_d = ST_PASS;
              done_d  = 1'b1;
              pass_d  = 1'b1;
            end
          end else begin
            state_d = ST_FAIL;
            done_d  = 1'b1;
            fc_d    = hit ? FC_DATA : FC_ADR;
            fa_d    = Adr;
            fd_d    = WriteData;
          end
        end
        // Timeout only fires when this edge's write neither completed nor failed.
        if (state_d == ST_RUN && cc_inc == CYC_W'(TIMEOUT)) begin
          state_d = ST_FAIL;
          done_d  = 1'b1;
          fc_d    = FC_TIMEOUT;
          fa_d    = '0;
          fd_d    = '0;
        end
      end
      ST_PASS, ST_FAIL: begin
        if (clear) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fc_d    = FC_NONE;
          fa_d    = '0;
          fd_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fc_q    <= FC_NONE;
      fa_q    <= '0;
      fd_q    <= '0;
      mc_q    <= '0;
      cc_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fc_q    <= fc_d;
      fa_q    <= fa_d;
      fd_q    <= fd_d;
      mc_q    <= mc_d;
      cc_q    <= cc_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_code = fc_q;
  assign fail_adr  = fa_q;
  assign fail_data = fd_q;
  assign match_cnt = mc_q;
  assign cycle_cnt = cc_q;
  assign mon_state = state_q;

endmodule

// File: tb/tb_write_monitor.sv
// Directed bench: four monitor configurations share one stimulus stream and
// each is checked against hand-computed expectations.
module tb_write_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exp_we = 1'b0;
  logic [0:0]  exp_idx = '0;
  logic [31:0] exp_adr = '0;
  logic [31:0] exp_data = '0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] write_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  // d1: N=1 ordered, ignore 96, timeout 20
  logic d1_done, d1_pass; logic [1:0] d1_fc, d1_st; logic [31:0] d1_fa, d1_fd;
  logic [0:0] d1_mc; logic [4:0] d1_cc;
  // d2: N=1, ignore disabled
  logic d2_done, d2_pass; logic [1:0] d2_fc, d2_st; logic [31:0] d2_fa, d2_fd;
  logic [0:0] d2_mc; logic [4:0] d2_cc;
  // d3: N=2 unordered; d4: N=2 ordered
  logic d3_done, d3_pass; logic [1:0] d3_fc, d3_st; logic [31:0] d3_fa, d3_fd;
  logic [1:0] d3_mc; logic [5:0] d3_cc;
  logic d4_done, d4_pass; logic [1:0] d4_fc, d4_st; logic [31:0] d4_fa, d4_fd;
  logic [1:0] d4_mc; logic [5:0] d4_cc;

  always #5 clk = ~clk;

  write_monitor #(.N_EXP(1), .TIMEOUT(20), .ORDERED(1'b1), .IGN_EN(1'b1), .IGN_ADR(32'd96)) u_d1 (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_adr(exp_adr),
    .exp_data(exp_data), .start(start), .clear(clear), .MemWrite(mem_write), .Adr(adr),
    .WriteData(write_data), .done(d1_done), .pass(d1_pass), .fail_code(d1_fc),
    .fail_adr(d1_fa), .fail_data(d1_fd), .match_cnt(d1_mc), .cycle_cnt(d1_cc), .mon_state(d1_st));

  write_monitor #(.N_EXP(1), .TIMEOUT(20), .ORDERED(1'b1), .IGN_EN(1'b0), .IGN_ADR(32'd96)) u_d2 (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_adr(exp_adr),
    .exp_data(exp_data), .start(start), .clear(clear), .MemWrite(mem_write), .Adr(adr),
    .WriteData(write_data), .done(d2_done), .pass(d2_pass), .fail_code(d2_fc),
    .fail_adr(d2_fa), .fail_data(d2_fd), .match_cnt(d2_mc), .cycle_cnt(d2_cc), .mon_state(d2_st));

  write_monitor #(.N_EXP(2), .TIMEOUT(50), .ORDERED(1'b0), .IGN_EN(1'b1), .IGN_ADR(32'd96)) u_d3 (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_adr(exp_adr),
    .exp_data(exp_data), .start(start), .clear(clear), .MemWrite(mem_write), .Adr(adr),
    .WriteData(write_data), .done(d3_done), .pass(d3_pass), .fail_code(d3_fc),
    .fail_adr(d3_fa), .fail_data(d3_fd), .match_cnt(d3_mc), .cycle_cnt(d3_cc), .mon_state(d3_st));

  write_monitor #(.N_EXP(2), .TIMEOUT(50), .ORDERED(1'b1), .IGN_EN(1'b1), .IGN_ADR(32'd96)) u_d4 (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_adr(exp_adr),
    .exp_data(exp_data), .start(start), .clear(clear), .MemWrite(mem_write), .Adr(adr),
    .WriteData(write_data), .done(d4_done), .pass(d4_pass), .fail_code(d4_fc),
    .fail_adr(d4_fa), .fail_data(d4_fd), .match_cnt(d4_mc), .cycle_cnt(d4_cc), .mon_state(d4_st));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_cycles(2);
    reset = 1'b0;
    tick();
  endtask

  task automatic load_entry(input logic [0:0] idx, input logic [31:0] a, input logic [31:0] d,
                            input logic with_start);
    exp_we = 1'b1; exp_idx = idx; exp_adr = a; exp_data = d; start = with_start;
    tick();
    exp_we = 1'b0; start = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1; adr = a; write_data = d;
    tick();
    mem_write = 1'b0;
  endtask

  initial begin
    idle_cycles(2);
    check_eq("rst_state", d1_st, 0);
    check_eq("rst_done", d1_done, 0);
    check_eq("rst_pass", d1_pass, 0);
    check_eq("rst_fc", d1_fc, 0);
    check_eq("rst_fa", d1_fa, 0);
    check_eq("rst_fd", d1_fd, 0);
    check_eq("rst_mc", d1_mc, 0);
    check_eq("rst_cc", d1_cc, 0);
    reset = 1'b0;
    tick();

    // Table write and start on the same edge; entry is live from the first RUN cycle.
    load_entry(1'b0, 32'd100, 32'd7, 1'b1);
    check_eq("s1_run", d1_st, 1);
    check_eq("s1_cc0", d1_cc, 0);
    mem_wr(32'd96, 32'd5);
    check_eq("s1_ign_state", d1_st, 1);
    check_eq("s1_ign_mc", d1_mc, 0);
    check_eq("s1_ign_cc", d1_cc, 1);
    check_eq("s1_noign_fc", d2_fc, 2);
    check_eq("s1_noign_fa", d2_fa, 96);
    check_eq("s1_noign_fd", d2_fd, 5);
    mem_wr(32'd100, 32'd7);
    check_eq("s1_pass_state", d1_st, 2);
    check_eq("s1_pass", d1_pass, 1);
    check_eq("s1_done", d1_done, 1);
    check_eq("s1_mc", d1_mc, 1);
    check_eq("s1_fc", d1_fc, 0);
    check_eq("s1_cc", d1_cc, 2);

    // Clear keeps the table: a re-run passes, then a wrong datum is a data mismatch.
    do_clear();
    check_eq("s2_clr_state", d1_st, 0);
    check_eq("s2_clr_done", d1_done, 0);
    start_run();
    mem_wr(32'd100, 32'd7);
    check_eq("s2_rerun_pass", d1_pass, 1);
    do_clear();
    start_run();
    mem_wr(32'd100, 32'd8);
    check_eq("s2_state", d1_st, 3);
    check_eq("s2_fc", d1_fc, 1);
    check_eq("s2_fa", d1_fa, 100);
    check_eq("s2_fd", d1_fd, 8);
    check_eq("s2_pass", d1_pass, 0);
    mem_wr(32'd104, 32'd1);
    idle_cycles(2);
    check_eq("s2_hold_fa", d1_fa, 100);
    check_eq("s2_hold_fc", d1_fc, 1);

    do_clear();
    start_run();
    mem_wr(32'd104, 32'd7);
    check_eq("s3_fc", d1_fc, 2);
    check_eq("s3_fa", d1_fa, 104);
    check_eq("s3_fd", d1_fd, 7);

    // Timeout after exactly 20 RUN edges.
    do_clear();
    start_run();
    idle_cycles(19);
    check_eq("s4_pre_state", d1_st, 1);
    check_eq("s4_pre_cc", d1_cc, 19);
    tick();
    check_eq("s4_state", d1_st, 3);
    check_eq("s4_fc", d1_fc, 3);
    check_eq("s4_cc", d1_cc, 20);
    check_eq("s4_fa", d1_fa, 0);
    check_eq("s4_done", d1_done, 1);

    do_clear();
    start_run();
    idle_cycles(19);
    mem_wr(32'd100, 32'd7);
    check_eq("s5_last_pass", d1_pass, 1);
    check_eq("s5_last_fc", d1_fc, 0);
    check_eq("s5_last_cc", d1_cc, 20);
    do_clear();
    start_run();
    idle_cycles(19);
    mem_wr(32'd100, 32'd8);
    check_eq("s5_mis_fc", d1_fc, 1);

    // Two-entry table, written out of order.
    do_reset();
    load_entry(1'b0, 32'd100, 32'd7, 1'b0);
    load_entry(1'b1, 32'd104, 32'd9, 1'b0);
    start_run();
    mem_wr(32'd104, 32'd9);
    check_eq("s6_ord_state", d4_st, 3);
    check_eq("s6_ord_fc", d4_fc, 2);
    check_eq("s6_ord_fa", d4_fa, 104);
    check_eq("s6_ord_fd", d4_fd, 9);
    check_eq("s6_uno_state", d3_st, 1);
    check_eq("s6_uno_mc1", d3_mc, 1);
    mem_wr(32'd100, 32'd7);
    check_eq("s6_uno_pass", d3_pass, 1);
    check_eq("s6_uno_mc2", d3_mc, 2);

    do_clear();
    start_run();
    mem_wr(32'd100, 32'd7);
    check_eq("s7_mc", d3_mc, 1);
    mem_wr(32'd100, 32'd7);
    check_eq("s7_dup_fc", d3_fc, 2);
    check_eq("s7_dup_fa", d3_fa, 100);
    do_clear();
    start_run();
    mem_wr(32'd104, 32'd1);
    check_eq("s7_data_fc", d3_fc, 1);
    check_eq("s7_data_fd", d3_fd, 1);

    // Asynchronous reset mid-run clears state and table.
    do_clear();
    start_run();
    mem_wr(32'd104, 32'd9);
    check_eq("s8_pre_mc", d3_mc, 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("s8_async_state", d3_st, 0);
    check_eq("s8_async_mc", d3_mc, 0);
    tick();
    reset = 1'b0;
    tick();
    start_run();
    mem_wr(32'd0, 32'd0);
    check_eq("s8_zero_mc", d3_mc, 1);
    check_eq("s8_zero_state", d3_st, 1);
    mem_wr(32'd0, 32'd0);
    check_eq("s8_zero_pass_uno", d3_pass, 1);
    check_eq("s8_zero_pass_ord", d4_pass, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/write_monitor.md
# write_monitor

Synthesizable, parametrised self-checking monitor for the multi-cycle processor top level. It watches the data-memory write port (MemWrite/Adr/WriteData) and compares each write against a loadable table of expected writes. It reports pass/fail, a failure code with the offending address and data, and a cycle-bounded timeout. It replaces the hard-wired "address 100 / data 7, else 96" check with N entries, ordered or unordered matching, and an optional ignore address. It sits beside `top` in benches and FPGA bring-up wrappers.

## Interface
Parameters:
- N_EXP, 4: number of expected-write table entries (1..16).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- TIMEOUT, 1000: maximum RUN cycles before failure (≥1).
- ORDERED, 1: 1 = entries must match in index order; 0 = any order, each entry at most once.
- IGN_EN, 1: 1 = writes to IGN_ADR are silently accepted.
- IGN_ADR, 96: ignored address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- exp_we  in  1  table write strobe; honoured only in IDLE.
- exp_idx  in  $clog2(N_EXP) (min 1)  table entry index.
- exp_adr  in  ADDR_W  expected address.
- exp_data  in  DATA_W  expected data.
- start  in  1  IDLE→RUN pulse.
- clear  in  1  PASS/FAIL→IDLE; table retained.
- MemWrite  in  1  observed write enable.
- Adr  in  ADDR_W  observed address.
- WriteData  in  DATA_W  observed data.
- done  out  1  high in PASS or FAIL.
- pass  out  1  high in PASS.
- fail_code  out  2  0 none, 1 data mismatch, 2 unexpected address, 3 timeout.
- fail_adr  out  ADDR_W  address of the failing write (0 for timeout).
- fail_data  out  DATA_W  data of the failing write (0 for timeout).
- match_cnt  out  $clog2(N_EXP+1)  entries matched so far.
- cycle_cnt  out  $clog2(TIMEOUT+1)  RUN cycles elapsed; saturates.
- mon_state  out  2  current state encoding.

## Operation
- States: IDLE=0, RUN=1, PASS=2, FAIL=3.
- IDLE: exp_we writes entry exp_idx. start → RUN, clears match_cnt, cycle_cnt and the matched mask.
- RUN: each cycle with MemWrite=1 is evaluated once.
  - Ignore rule: IGN_EN=1 and Adr==IGN_ADR → no effect (checked first).
  - ORDERED=1: compare against entry match_cnt.
    - Adr and data equal → match_cnt+1.
    - Adr equal, data differs → FAIL, code 1.
    - Adr differs → FAIL, code 2.
  - ORDERED=0: search unmatched entries, lowest index first.
    - Full match → set that mask bit, match_cnt+1.
    - Address hit on an unmatched entry with wrong data → code 1.
    - No address hit → code 2. Writes to already-matched addresses count as code 2.
  - match_cnt reaching N_EXP → PASS.
- Timeout: cycle_cnt==TIMEOUT while in RUN and not completing → FAIL, code 3.
- PASS/FAIL hold all outputs until clear or reset. MemWrite is ignored there.
- Ignored inputs, no effect: start outside IDLE, clear outside PASS/FAIL, exp_we outside IDLE.

## Timing
- Reset values:
  - mon_state=IDLE.
  - done, pass, fail_code, fail_adr, fail_data, match_cnt, cycle_cnt = 0.
  - Table entries and mask = 0.
- All outputs are registered. A write sampled at edge k updates match_cnt/state/fail_* visible after edge k (one-cycle latency).
- cycle_cnt increments at every edge spent in RUN, starting at 1 after the first RUN edge.
- Same-edge events:
  - A write completing the final match on the timeout edge wins (PASS).
  - A mismatching write on the timeout edge reports its code (1 or 2), not 3.
- start and exp_we on the same IDLE edge: the table write takes effect, then RUN begins. The entry is usable from the first RUN cycle.
- Reset asserted mid-RUN: immediate return to IDLE with the table cleared. Release is synchronous to the next clk edge.

## Structure
- Package `mon_pkg`: state encoding localparams, fail-code constants (FC_NONE, FC_DATA, FC_ADR, FC_TIMEOUT).
- Sub-module `exp_table`: entry storage, matched mask and combinational match/hit search. It returns hit, full_match and index.
- `write_monitor` holds the FSM, counters and fail capture.

## Test plan
- N_EXP=1, entry (100,7). Writes (96,x) then (100,7) → PASS, match_cnt=1, fail_code=0.
- Same table, write (100,8) → FAIL, fail_code=1, fail_adr=100, fail_data=8.
- Same table, write (104,7) → FAIL, fail_code=2. With IGN_EN=0, a write (96,3) → fail_code=2.
- TIMEOUT=20, no writes → FAIL, fail_code=3 after 20 RUN cycles, cycle_cnt=20. Also drive the final matching write on cycle 20 → PASS.
- ORDERED=0, entries (100,7), (104,9). Writes (104,9), (100,7) → PASS. Repeat with ORDERED=1 → FAIL, code 2 at 104.
- Reset asserted after one of two matches → IDLE, match_cnt=0, table zeroed. clear from PASS → IDLE with the table intact, and re-run passes.
